// File: rtl/cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
// Shared types and helpers for the CPU-side sram-like bus logic.
//   bus_state_e : request FSM states (IDLE / ADDR / DATA)
//   strb_to_wr  : reduces a byte-strobe vector to a write flag
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no transaction outstanding
        ST_ADDR = 2'd1,   // bus_req high, waiting for addr_ok
        ST_DATA = 2'd2    // address accepted, waiting for data_ok
    } bus_state_e;

    // Any enabled byte lane makes the access a write. Callers zero-extend
    // their strobe vector to 64 bits (enough for 512-bit data).
    function automatic logic strb_to_wr(input logic [63:0] strb);
        return |strb;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Scans req_i starting at index ptr_i and
// wrapping around; the first requester found wins.
// Ports:
//   req_i       [N]  request vector
//   ptr_i       [IW] index to start the scan from (must be < N)
//   grant_o     [N]  one-hot grant, all zero when nothing requests
//   grant_idx_o [IW] index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            // (ptr + k) mod N with a single conditional subtract; ptr < N so
            // the sum never reaches 2N.
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/cpu_sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_sram_like_arbiter
// Merges NCH CPU memory channels (0 = fetch, 1 = data, ...) onto one
// sram-like request/handshake bus with a single outstanding transaction.
// Per-channel stall holds the CPU until its access has completed; completed
// channels stay marked done until the whole pipeline may advance.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ch_en/ch_wen/ch_addr/ch_wdata  per-channel request (packed, slice i)
//   ch_rdata                       per-channel registered read data
//   ch_stall                       per-channel "access not yet complete"
//   hold                           external freeze, blocks release of done
//   bus_req/wr/wstrb/addr/wdata    registered request to the bus
//   bus_addr_ok/rdata/data_ok      bus handshake and response
// ---------------------------------------------------------------------------
module cpu_sram_like_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NCH    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NCH-1:0]               ch_en,
    input  logic [NCH*(DATA_W/8)-1:0]    ch_wen,
    input  logic [NCH*ADDR_W-1:0]        ch_addr,
    input  logic [NCH*DATA_W-1:0]        ch_wdata,
    output logic [NCH*DATA_W-1:0]        ch_rdata,
    output logic [NCH-1:0]               ch_stall,
    input  logic                         hold,
    output logic                         bus_req,
    output logic                         bus_wr,
    output logic [(DATA_W/8)-1:0]        bus_wstrb,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [DATA_W-1:0]            bus_wdata,
    input  logic                         bus_addr_ok,
    input  logic [DATA_W-1:0]            bus_rdata,
    input  logic                         bus_data_ok
);

    localparam int WS = DATA_W / 8;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    bus_state_e        state_q, state_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NCH-1:0]    done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WS-1:0]     wstrb_q, wstrb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [ADDR_W-1:0] ch_addr_a  [NCH];
    logic [WS-1:0]     ch_wen_a   [NCH];
    logic [DATA_W-1:0] ch_wdata_a [NCH];

    logic              data_done;
    logic [NCH-1:0]    completed_oh;
    logic [NCH-1:0]    arb_req;
    logic [NCH-1:0]    arb_grant;
    logic [IW-1:0]     arb_idx;
    logic [IW-1:0]     arb_ptr;
    logic [IW-1:0]     ptr_after;
    logic              arb_valid;
    logic              latch;
    logic              release_done;

    // data_ok only counts while a transaction is in its data phase; any
    // data_ok seen in IDLE or ADDR (including after a reset) is ignored.
    assign data_done = (state_q == ST_DATA) && bus_data_ok;

    genvar gi;
    for (gi = 0; gi < NCH; gi++) begin : g_ch
        logic [DATA_W-1:0] rdata_q;

        assign ch_addr_a[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
        assign ch_wen_a[gi]   = ch_wen[gi*WS +: WS];
        assign ch_wdata_a[gi] = ch_wdata[gi*DATA_W +: DATA_W];

        assign completed_oh[gi] = data_done && (gnt_q == IW'(gi));
        assign ch_stall[gi]     = ch_en[gi] & ~done_q[gi] & ~completed_oh[gi];

        // Read data is captured even if the channel dropped ch_en mid-flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (completed_oh[gi] && !strb_to_wr(64'(wstrb_q))) begin
                rdata_q <= bus_rdata;
            end
        end

        assign ch_rdata[gi*DATA_W +: DATA_W] = rdata_q;
    end

    // Pointer value after completing the current grant.
    assign ptr_after = (gnt_q == IW'(NCH-1)) ? '0 : gnt_q + 1'b1;

    // In the completion cycle the finishing channel is excluded and the scan
    // already starts after it, so a back-to-back issue goes to someone else.
    assign arb_req   = ch_en & ~done_q & ~completed_oh;
    assign arb_ptr   = data_done ? ptr_after : rr_ptr_q;
    assign arb_valid = |arb_grant;

    rr_arbiter #(
        .N  (NCH),
        .IW (IW)
    ) u_rr (
        .req_i       (arb_req),
        .ptr_i       (arb_ptr),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx)
    );

    // done[] clears only when nobody is stalled and the pipeline is free to
    // move; otherwise a finished fetch would be re-issued while the data
    // access is still waiting.
    assign release_done = !hold && !(|ch_stall);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        latch    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    latch   = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    rr_ptr_d = ptr_after;
                    if (arb_valid) begin
                        latch   = 1'b1;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (latch) begin
            gnt_d   = arb_idx;
            addr_d  = ch_addr_a[arb_idx];
            wstrb_d = ch_wen_a[arb_idx];
            wdata_d = ch_wdata_a[arb_idx];
        end

        done_d = release_done ? '0 : (done_q | (completed_oh & ch_en));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            done_q   <= '0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus_req   = (state_q == ST_ADDR);
    assign bus_wr    = strb_to_wr(64'(wstrb_q));
    assign bus_wstrb = wstrb_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_cpu_sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_sram_like_arbiter
// Directed scenarios with literal expectations followed by randomized
// traffic. A transaction-level model (one outstanding access record, done
// flags, rr pointer) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_cpu_sram_like_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 2;
    localparam int WS = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ch_en;
    logic [N*WS-1:0] ch_wen;
    logic [N*AW-1:0] ch_addr;
    logic [N*DW-1:0] ch_wdata;
    logic [N*DW-1:0] ch_rdata;
    logic [N-1:0]    ch_stall;
    logic            hold;
    logic            bus_req;
    logic            bus_wr;
    logic [WS-1:0]   bus_wstrb;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic            bus_addr_ok;
    logic [DW-1:0]   bus_rdata;
    logic            bus_data_ok;

    always #5 clk = ~clk;

    cpu_sram_like_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .NCH    (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_en       (ch_en),
        .ch_wen      (ch_wen),
        .ch_addr     (ch_addr),
        .ch_wdata    (ch_wdata),
        .ch_rdata    (ch_rdata),
        .ch_stall    (ch_stall),
        .hold        (hold),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_rdata   (bus_rdata),
        .bus_data_ok (bus_data_ok)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- transaction-level model ----------------
    bit            m_valid = 1'b0;  // model meaningful once a reset was seen
    bit            m_busy;          // an access is outstanding
    bit            m_acc;           // its address has been accepted
    int            m_ch;
    logic [AW-1:0] m_addr;
    logic [WS-1:0] m_wstrb;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata [N];
    bit            m_done  [N];
    int            m_ptr;
    logic [N-1:0]  prev_stall = '0;

    function automatic logic [N-1:0] model_stall();
        logic [N-1:0] s;
        for (int i = 0; i < N; i++) begin
            s[i] = ch_en[i] && !m_done[i] &&
                   !(m_busy && m_acc && bus_data_ok && m_ch == i);
        end
        return s;
    endfunction

    task automatic model_step();
        logic [N-1:0] st;
        bit           completing;
        int           fin_ch;
        int           ptr;
        bit           n_done [N];
        bit           found;
        int           c;
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_acc   = 1'b0;
            m_ch    = 0;
            m_addr  = '0;
            m_wstrb = '0;
            m_wdata = '0;
            m_ptr   = 0;
            for (int i = 0; i < N; i++) begin
                m_rdata[i] = '0;
                m_done[i]  = 1'b0;
            end
            return;
        end
        if (!m_valid) return;
        st         = model_stall();
        completing = m_busy && m_acc && bus_data_ok;
        fin_ch     = -1;
        ptr        = m_ptr;
        for (int i = 0; i < N; i++) n_done[i] = m_done[i];
        if (completing) begin
            if (m_wstrb == '0) m_rdata[m_ch] = bus_rdata;
            if (ch_en[m_ch]) n_done[m_ch] = 1'b1;
            ptr    = (m_ch + 1) % N;
            fin_ch = m_ch;
            m_busy = 1'b0;
        end else if (m_busy && !m_acc && bus_addr_ok) begin
            m_acc = 1'b1;
        end
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (ptr + k) % N;
                if (!found && ch_en[c] && !m_done[c] && c != fin_ch) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_acc   = 1'b0;
                    m_ch    = c;
                    m_addr  = ch_addr[c*AW +: AW];
                    m_wstrb = ch_wen[c*WS +: WS];
                    m_wdata = ch_wdata[c*DW +: DW];
                end
            end
        end
        if (!hold && st == '0) begin
            for (int i = 0; i < N; i++) n_done[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) m_done[i] = n_done[i];
        m_ptr = ptr;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (!m_valid) return;
        chk("m_stall", 64'(ch_stall), 64'(model_stall()));
        chk("m_req", 64'(bus_req), 64'(m_busy && !m_acc));
        chk("m_wr", 64'(bus_wr), 64'(m_wstrb != '0));
        chk("m_wstrb", 64'(bus_wstrb), 64'(m_wstrb));
        chk("m_addr", 64'(bus_addr), 64'(m_addr));
        chk("m_wdata", 64'(bus_wdata), 64'(m_wdata));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("m_rdata%0d", i), 64'(ch_rdata[i*DW +: DW]), 64'(m_rdata[i]));
        end
    endtask

    // Inputs are driven at posedge+1; outputs are sampled at posedge+4.
    task automatic settle();
        #3;
    endtask

    task automatic finish_cycle();
        compare_model();
        prev_stall = model_stall();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input bit en, input logic [WS-1:0] wen,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_en[i]             = en;
        ch_wen[i*WS +: WS]   = wen;
        ch_addr[i*AW +: AW]  = a;
        ch_wdata[i*DW +: DW] = d;
    endtask

    task automatic bus(input bit aok, input bit dok, input logic [DW-1:0] rd);
        bus_addr_ok = aok;
        bus_data_ok = dok;
        bus_rdata   = rd;
    endtask

    function automatic logic [DW-1:0] rd_of(input int i);
        return ch_rdata[i*DW +: DW];
    endfunction

    initial begin
        rst = 1'b1; hold = 1'b0;
        ch_en = '0; ch_wen = '0; ch_addr = '0; ch_wdata = '0;
        bus(0, 0, '0);
        set_ch(0, 1, '0, 32'h0, 32'h0);
        set_ch(1, 1, '0, 32'h0, 32'h0);

        // Reset state
        #1; settle(); finish_cycle();
        settle();
        chk("rst_stall_eq_en", 64'(ch_stall), 64'h3);
        chk("rst_req", 64'(bus_req), 64'h0);
        chk("rst_addr", 64'(bus_addr), 64'h0);
        chk("rst_rdata", 64'(ch_rdata), 64'h0);
        finish_cycle();
        rst = 1'b0;
        set_ch(0, 0, '0, 32'h0, 32'h0);
        set_ch(1, 0, '0, 32'h0, 32'h0);
        settle(); finish_cycle();

        // Single read, minimum latency
        set_ch(1, 1, '0, 32'h100, 32'h0); bus(0, 0, '0);
        settle(); chk("rd_c0_req", 64'(bus_req), 64'h0); chk("rd_c0_stall", 64'(ch_stall), 64'h2); finish_cycle();
        bus(1, 0, '0);
        settle(); chk("rd_c1_req", 64'(bus_req), 64'h1); chk("rd_c1_addr", 64'(bus_addr), 64'h100); finish_cycle();
        bus(0, 1, 32'hDEADBEEF);
        settle(); chk("rd_c2_stall", 64'(ch_stall), 64'h0); chk("rd_c2_req", 64'(bus_req), 64'h0); finish_cycle();
        set_ch(1, 0, '0, 32'h100, 32'h0); bus(0, 0, '0);
        settle(); chk("rd_c3_rdata", 64'(rd_of(1)), 64'hDEADBEEF); chk("rd_c3_req", 64'(bus_req), 64'h0); finish_cycle();

        // Write leaves ch_rdata alone
        set_ch(1, 1, 4'b0011, 32'h200, 32'h1234);
        settle(); finish_cycle();
        bus(1, 0, '0);
        settle(); chk("wr_bus_wr", 64'(bus_wr), 64'h1); chk("wr_wstrb", 64'(bus_wstrb), 64'h3);
        chk("wr_wdata", 64'(bus_wdata), 64'h1234); finish_cycle();
        bus(0, 1, 32'hFFFFFFFF);
        settle(); finish_cycle();
        set_ch(1, 0, '0, 32'h0, 32'h0); bus(0, 0, '0);
        settle(); chk("wr_rdata_kept", 64'(rd_of(1)), 64'hDEADBEEF); finish_cycle();

        // addr_ok withheld for 5 cycles
        set_ch(0, 1, '0, 32'h40, 32'h0);
        settle(); finish_cycle();
        for (int k = 0; k < 6; k++) begin
            bus(k == 5, 0, '0);
            settle();
            chk($sformatf("wait_req_%0d", k), 64'(bus_req), 64'h1);
            chk($sformatf("wait_addr_%0d", k), 64'(bus_addr), 64'h40);
            chk($sformatf("wait_stall_%0d", k), 64'(ch_stall), 64'h1);
            finish_cycle();
        end
        bus(0, 1, 32'hCAFEF00D);
        settle(); finish_cycle();
        set_ch(0, 0, '0, 32'h0, 32'h0); bus(0, 0, '0);
        settle(); chk("wait_rdata", 64'(rd_of(0)), 64'hCAFEF00D); finish_cycle();

        // hold during completion
        set_ch(0, 1, '0, 32'h80, 32'h0); hold = 1'b1;
        settle(); finish_cycle();
        bus(1, 0, '0); settle(); finish_cycle();
        bus(0, 1, 32'h0BADF00D);
        settle(); chk("hold_done_stall", 64'(ch_stall), 64'h0); finish_cycle();
        bus(0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("hold_stall_%0d", k), 64'(ch_stall), 64'h0);
            chk($sformatf("hold_noreq_%0d", k), 64'(bus_req), 64'h0);
            finish_cycle();
        end
        hold = 1'b0;
        settle(); chk("hold_rel_req", 64'(bus_req), 64'h0); finish_cycle();
        settle(); chk("hold_after_stall", 64'(ch_stall), 64'h1); finish_cycle();
        bus(1, 0, '0);
        settle(); chk("hold_reissue_req", 64'(bus_req), 64'h1); chk("hold_reissue_addr", 64'(bus_addr), 64'h80);
        finish_cycle();
        bus(0, 1, 32'h0BADF00D); settle(); finish_cycle();
        set_ch(0, 0, '0, 32'h0, 32'h0); bus(0, 0, '0); settle(); finish_cycle();

        // Reset while in DATA, stale data_ok afterwards
        set_ch(1, 1, '0, 32'h300, 32'h0);
        settle(); finish_cycle();
        bus(1, 0, '0); settle(); finish_cycle();
        bus(0, 0, '0); rst = 1'b1; settle(); finish_cycle();
        rst = 1'b0; set_ch(1, 0, '0, 32'h300, 32'h0); bus(0, 1, 32'h55555555);
        settle(); chk("mrst_req", 64'(bus_req), 64'h0); chk("mrst_addr", 64'(bus_addr), 64'h0);
        chk("mrst_rdata", 64'(ch_rdata), 64'h0); finish_cycle();
        bus(0, 0, '0);
        settle(); chk("mrst_stale", 64'(rd_of(1)), 64'h0); finish_cycle();

        // Both channels after reset: ch0 first, ch1 back-to-back
        set_ch(0, 1, '0, 32'h10, 32'h0);
        set_ch(1, 1, '0, 32'h20, 32'h0);
        settle(); finish_cycle();
        bus(1, 0, '0);
        settle(); chk("both_first_addr", 64'(bus_addr), 64'h10); finish_cycle();
        bus(0, 1, 32'hAAAA0000);
        settle(); chk("both_c2_stall", 64'(ch_stall), 64'h2); finish_cycle();
        bus(1, 0, '0);
        settle(); chk("both_b2b_req", 64'(bus_req), 64'h1); chk("both_b2b_addr", 64'(bus_addr), 64'h20);
        chk("both_c3_stall", 64'(ch_stall), 64'h2); finish_cycle();
        bus(0, 1, 32'h0000BBBB);
        settle(); chk("both_c4_stall", 64'(ch_stall), 64'h0); finish_cycle();
        set_ch(0, 0, '0, 32'h0, 32'h0); set_ch(1, 0, '0, 32'h0, 32'h0); bus(0, 0, '0);
        settle(); chk("both_rd0", 64'(rd_of(0)), 64'hAAAA0000); chk("both_rd1", 64'(rd_of(1)), 64'h0000BBBB);
        chk("both_c5_req", 64'(bus_req), 64'h0); finish_cycle();

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst  = ($urandom_range(0, 499) == 0);
            hold = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (prev_stall[i]) begin
                    if ($urandom_range(0, 31) == 0) ch_en[i] = 1'b0;
                end else begin
                    ch_en[i]             = ($urandom_range(0, 2) != 0);
                    ch_wen[i*WS +: WS]   = ($urandom_range(0, 1) == 1) ? WS'($urandom) : '0;
                    ch_addr[i*AW +: AW]  = $urandom;
                    ch_wdata[i*DW +: DW] = $urandom;
                end
            end
            bus(m_busy && !m_acc && ($urandom_range(0, 2) == 0),
                m_busy && m_acc && ($urandom_range(0, 2) == 0),
                $urandom);
            settle();
            finish_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
